// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the FIFO reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_GAP    = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } rst_state_e;

  localparam int MIN_ASSERT_CYC = 2;
  localparam int MIN_GAP_CYC    = 1;
  localparam int MIN_DRAIN_TO   = 1;

  // One counter covers every timed state, so it is sized by the longest one.
  function automatic int cnt_width(input int assert_cyc, input int gap_cyc, input int drain_to);
    int m;
    m = assert_cyc;
    if (gap_cyc > m) m = gap_cyc;
    if (drain_to > m) m = drain_to;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/rst_seq_gen.sv
// Issues ordered, stretched active-low resets to the FIFO read and write sides:
// drain writers, hold both resets, release read side, then write side after a gap.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int ASSERT_CYC = 16,
  parameter int GAP_CYC    = 4,
  parameter int DRAIN_TO   = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sw_rst_req,
  input  logic i_quiesce,
  output logic o_drain_req,
  output logic o_rd_rst_n,
  output logic o_wr_rst_n,
  output logic o_rst_busy,
  output logic o_rst_done,
  output logic o_drain_to
);

  localparam int CW = cnt_width(ASSERT_CYC, GAP_CYC, DRAIN_TO);
  localparam logic [CW-1:0] ASSERT_LAST = CW'(ASSERT_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_TO - 1);

  generate
    if (ASSERT_CYC < MIN_ASSERT_CYC) begin : g_bad_assert
      $error("rst_seq_gen: ASSERT_CYC below minimum");
    end
    if (GAP_CYC < MIN_GAP_CYC) begin : g_bad_gap
      $error("rst_seq_gen: GAP_CYC below minimum");
    end
    if (DRAIN_TO < MIN_DRAIN_TO) begin : g_bad_drain
      $error("rst_seq_gen: DRAIN_TO below minimum");
    end
  endgenerate

  // Current sequencer state, kept as a named signal so checkers can bind to it.
  rst_state_e    state;
  logic [CW-1:0] cnt;

  // Drain handshake: o_drain_req is a level held from the cycle after the
  // request until reset asserts; i_quiesce is a level sampled each edge while
  // o_drain_req is high, and a high sample ends the drain on that same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_ASSERT;
      cnt         <= '0;
      o_rd_rst_n  <= 1'b0;
      o_wr_rst_n  <= 1'b0;
      o_rst_busy  <= 1'b1;
      o_drain_req <= 1'b0;
      o_rst_done  <= 1'b0;
      o_drain_to  <= 1'b0;
    end else begin
      o_rst_done <= 1'b0;
      o_drain_to <= 1'b0;
      case (state)
        ST_ASSERT: begin
          o_rd_rst_n <= 1'b0;
          o_wr_rst_n <= 1'b0;
          o_rst_busy <= 1'b1;
          if (cnt == ASSERT_LAST) begin
            o_rd_rst_n <= 1'b1;
            cnt        <= '0;
            state      <= ST_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            o_wr_rst_n <= 1'b1;
            o_rst_done <= 1'b1;
            o_rst_busy <= 1'b0;
            cnt        <= '0;
            state      <= ST_RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (i_sw_rst_req) begin
            o_drain_req <= 1'b1;
            o_rst_busy  <= 1'b1;
            cnt         <= '0;
            state       <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Quiesce wins over a timeout landing on the same edge.
          if (i_quiesce || (cnt == DRAIN_LAST)) begin
            o_rd_rst_n  <= 1'b0;
            o_wr_rst_n  <= 1'b0;
            o_drain_req <= 1'b0;
            o_drain_to  <= ~i_quiesce;
            cnt         <= '0;
            state       <= ST_ASSERT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          o_rd_rst_n  <= 1'b0;
          o_wr_rst_n  <= 1'b0;
          o_rst_busy  <= 1'b1;
          o_drain_req <= 1'b0;
          cnt         <= '0;
          state       <= ST_ASSERT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: default and minimum-parameter instances share clock and reset.
module tb_rst_seq_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n    = 1'b1;
  logic req      = 1'b0;
  logic quiesce  = 1'b0;
  logic req2     = 1'b0;
  logic quiesce2 = 1'b0;

  logic drain1, rd1, wr1, busy1, done1, to1;
  logic drain2, rd2, wr2, busy2, done2, to2;

  // Observation vector order: {rd, wr, busy, drain_req, done, drain_to}
  wire [5:0] obs1 = {rd1, wr1, busy1, drain1, done1, to1};
  wire [5:0] obs2 = {rd2, wr2, busy2, drain2, done2, to2};

  int checks = 0;
  int errors = 0;

  rst_seq_gen dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sw_rst_req(req),
    .i_quiesce   (quiesce),
    .o_drain_req (drain1),
    .o_rd_rst_n  (rd1),
    .o_wr_rst_n  (wr1),
    .o_rst_busy  (busy1),
    .o_rst_done  (done1),
    .o_drain_to  (to1)
  );

  rst_seq_gen #(.ASSERT_CYC(2), .GAP_CYC(1), .DRAIN_TO(1)) dut_min (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sw_rst_req(req2),
    .i_quiesce   (quiesce2),
    .o_drain_req (drain2),
    .o_rd_rst_n  (rd2),
    .o_wr_rst_n  (wr2),
    .o_rst_busy  (busy2),
    .o_rst_done  (done2),
    .o_drain_to  (to2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (obs1 !== 6'b001000) begin
      errors++;
      $display("FAIL reset_dflt got %b exp %b", obs1, 6'b001000);
    end
    checks++;
    if (obs2 !== 6'b001000) begin
      errors++;
      $display("FAIL reset_min got %b exp %b", obs2, 6'b001000);
    end
    req = 1'b1;
    quiesce = 1'b1;
    tick();
    checks++;
    if (obs1 !== 6'b001000) begin
      errors++;
      $display("FAIL reset_req_held got %b exp %b", obs1, 6'b001000);
    end
    req = 1'b0;
    quiesce = 1'b0;
  endtask

  task automatic test_power_on(input string tag);
    logic [5:0] exp1, exp2;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      tick();
      exp1 = {(e >= 16), (e >= 20), (e < 20), 1'b0, (e == 20), 1'b0};
      exp2 = {(e >= 2), (e >= 3), (e < 3), 1'b0, (e == 3), 1'b0};
      checks++;
      if (obs1 !== exp1) begin
        errors++;
        $display("FAIL %s_dflt edge %0d got %b exp %b", tag, e, obs1, exp1);
      end
      checks++;
      if (obs2 !== exp2) begin
        errors++;
        $display("FAIL %s_min edge %0d got %b exp %b", tag, e, obs2, exp2);
      end
    end
  endtask

  task automatic test_sw_quiesce();
    logic [5:0] exp;
    quiesce = 1'b1;
    req = 1'b1;
    tick();
    req = 1'b0;
    checks++;
    if (obs1 !== 6'b111100) begin
      errors++;
      $display("FAIL swq_drain got %b exp %b", obs1, 6'b111100);
    end
    for (int j = 1; j <= 22; j++) begin
      tick();
      exp = {(j >= 17), (j >= 21), (j < 21), 1'b0, (j == 21), 1'b0};
      checks++;
      if (obs1 !== exp) begin
        errors++;
        $display("FAIL swq_seq k+%0d got %b exp %b", j, obs1, exp);
      end
    end
  endtask

  task automatic test_drain_timeout();
    logic [5:0] exp;
    int m;
    quiesce = 1'b0;
    req = 1'b1;
    tick();
    req = 1'b0;
    checks++;
    if (obs1 !== 6'b111100) begin
      errors++;
      $display("FAIL to_drain got %b exp %b", obs1, 6'b111100);
    end
    for (int j = 1; j <= 85; j++) begin
      tick();
      m = j - 64;
      if (j < 64)       exp = 6'b111100;
      else if (j == 64) exp = 6'b001001;
      else              exp = {(m >= 16), (m >= 20), (m < 20), 1'b0, (m == 20), 1'b0};
      checks++;
      if (obs1 !== exp) begin
        errors++;
        $display("FAIL to_seq k+%0d got %b exp %b", j, obs1, exp);
      end
    end
  endtask

  task automatic test_min_params();
    logic [5:0] exp_tab [1:5];
    exp_tab[1] = 6'b001001;
    exp_tab[2] = 6'b001000;
    exp_tab[3] = 6'b101000;
    exp_tab[4] = 6'b110010;
    exp_tab[5] = 6'b110000;
    quiesce2 = 1'b0;
    req2 = 1'b1;
    tick();
    req2 = 1'b0;
    checks++;
    if (obs2 !== 6'b111100) begin
      errors++;
      $display("FAIL min_drain got %b exp %b", obs2, 6'b111100);
    end
    for (int j = 1; j <= 5; j++) begin
      tick();
      checks++;
      if (obs2 !== exp_tab[j]) begin
        errors++;
        $display("FAIL min_seq k+%0d got %b exp %b", j, obs2, exp_tab[j]);
      end
    end
  endtask

  task automatic test_async_reset_gap();
    quiesce = 1'b1;
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (18) tick();
    checks++;
    if (obs1 !== 6'b101000) begin
      errors++;
      $display("FAIL arst_in_gap got %b exp %b", obs1, 6'b101000);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs1 !== 6'b001000) begin
      errors++;
      $display("FAIL arst_immediate_dflt got %b exp %b", obs1, 6'b001000);
    end
    checks++;
    if (obs2 !== 6'b001000) begin
      errors++;
      $display("FAIL arst_immediate_min got %b exp %b", obs2, 6'b001000);
    end
    test_power_on("arst_restart");
  endtask

  task automatic test_req_ignored();
    int done_cnt;
    done_cnt = 0;
    quiesce = 1'b1;
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    req = 1'b1;
    for (int j = 2; j <= 40; j++) begin
      tick();
      if (j == 20) req = 1'b0;
      if (done1 === 1'b1) done_cnt++;
      checks++;
      if (wr1 === 1'b1 && rd1 !== 1'b1) begin
        errors++;
        $display("FAIL ign_order k+%0d got rd=%b wr=%b exp rd=1 when wr=1", j, rd1, wr1);
      end
      if (j >= 22) begin
        checks++;
        if (drain1 !== 1'b0) begin
          errors++;
          $display("FAIL ign_no_queue k+%0d got %b exp 0", j, drain1);
        end
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL ign_done_count got %0d exp 1", done_cnt);
    end
    checks++;
    if (obs1 !== 6'b110000) begin
      errors++;
      $display("FAIL ign_final got %b exp %b", obs1, 6'b110000);
    end
  endtask

  task automatic test_held_req();
    quiesce = 1'b1;
    req = 1'b1;
    tick();
    checks++;
    if (obs1 !== 6'b111100) begin
      errors++;
      $display("FAIL held_drain got %b exp %b", obs1, 6'b111100);
    end
    repeat (21) tick();
    checks++;
    if (obs1 !== 6'b110010) begin
      errors++;
      $display("FAIL held_done got %b exp %b", obs1, 6'b110010);
    end
    tick();
    checks++;
    if (obs1 !== 6'b111100) begin
      errors++;
      $display("FAIL held_restart got %b exp %b", obs1, 6'b111100);
    end
    req = 1'b0;
    tick();
    checks++;
    if (obs1 !== 6'b001000) begin
      errors++;
      $display("FAIL held_assert got %b exp %b", obs1, 6'b001000);
    end
    repeat (20) tick();
    checks++;
    if (obs1 !== 6'b110010) begin
      errors++;
      $display("FAIL held_done2 got %b exp %b", obs1, 6'b110010);
    end
  endtask

  initial begin
    test_reset();
    test_power_on("power_on");
    test_sw_quiesce();
    test_drain_timeout();
    test_min_params();
    test_async_reset_gap();
    test_req_ignored();
    test_held_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
